pipe_hold_ctrl: RTL and testbench
=================================

// Module: pipe_hold_ctrl
// PURPOSE
//  Pipeline sequencer for the J1 core's set/hold pipeline registers. Arbitrates jump, interrupt,
//  multi-cycle-op and bus-stall requests, then drives the hold inputs of the IF/ID and ID/EX
//  registers, the PC stall and the PC redirect. A hold loads the register's set value (a NOP bubble).
//  It sits between the EX stage, the multi-cycle unit (neuron update / divide), the bus and the PC.
// PARAMETERS
//  AW        16   PC / jump address width
//  FLUSH_CYC 2    cycles that flush stays asserted per redirect (>=1); covers fetch latency
//  TOW       8    width of the multi-cycle timeout counter; timeout at 2**TOW-1 cycles
// PORTS
//  clk              in   1   clock
//  rst              in   1   synchronous reset, active-high
//  jump_req_i       in   1   EX resolves a taken jump/branch this cycle
//  jump_addr_i      in   AW  target for jump_req_i
//  mc_start_i       in   1   EX issues a multi-cycle op this cycle
//  mc_done_i        in   1   multi-cycle unit result valid (1-cycle pulse)
//  bus_busy_i       in   1   data bus not ready; pipeline must freeze
//  irq_req_i        in   1   level interrupt request, held until irq_ack_o
//  irq_vec_i        in   AW  interrupt vector address
//  stall_o          out  1   freeze PC and IF/ID
//  flush_ifid_o     out  1   hold (bubble) IF/ID register
//  flush_idex_o     out  1   hold (bubble) ID/EX register
//  jump_flag_o      out  1   load PC from jump_addr_o
//  jump_addr_o      out  AW  redirect address
//  irq_ack_o        out  1   1-cycle acknowledge of irq_req_i
//  timeout_o        out  1   sticky: multi-cycle op timed out; cleared only by rst
// BEHAVIOUR
//  States: IDLE, FLUSH, MC_WAIT. Reset -> IDLE, flush counter=0, timeout counter=0, timeout_o=0.
//  While rst=1, all outputs are 0, including the combinational ones. Reset mid-FLUSH or mid-MC_WAIT
//  abandons the operation. The first post-reset cycle is IDLE.
//  IDLE priority (highest first): jump_req_i > mc_start_i > irq_req_i > bus_busy_i.
//  - jump: same cycle: jump_flag_o=1, jump_addr_o=jump_addr_i, flush_ifid_o=flush_idex_o=1.
//    If FLUSH_CYC>1, go to FLUSH for FLUSH_CYC-1 cycles; otherwise stay in IDLE.
//  - mc_start: same cycle: stall_o=1, flush_idex_o=1. Go to MC_WAIT with counter=0.
//  - irq: same cycle: jump_flag_o=1, jump_addr_o=irq_vec_i, irq_ack_o=1, both flushes=1.
//    Then FLUSH exactly as for a jump.
//  - bus_busy only: stall_o=1, flush_idex_o=1, combinational. No state change.
//  - Nothing requested: all outputs 0. jump_addr_o holds its last value (registered mux).
//  FLUSH: flush_ifid_o=flush_idex_o=1, jump_flag_o=0.
//    Flush counter decrements each cycle; return to IDLE after the last flush cycle.
//    irq_req_i is not sampled in FLUSH and stays pending. jump_req_i/mc_start_i are ignored
//    (EX holds a bubble).
//  MC_WAIT: stall_o=1, flush_idex_o=1 every cycle. Counter increments each cycle.
//    - mc_done_i=1: stall_o and flush_idex_o are still 1 this cycle; IDLE next cycle.
//    - counter reaches 2**TOW-1 without mc_done_i: timeout_o set; IDLE next cycle.
//    - mc_done_i together with the terminal count: done wins, timeout_o not set.
//    - bus_busy_i and irq_req_i are ignored; irq stays pending.
//    - jump_req_i is illegal here and ignored.
//  Simultaneous requests in IDLE: only the highest-priority request is serviced.
//    A losing irq stays pending; a losing mc_start is dropped (EX is flushed).
//  Latency: redirect and flush take effect in the request cycle (0 cycles).
//  Bubbles per redirect = FLUSH_CYC. Counters wrap never: saturate/exit as above.
// TESTING
//  1 Reset: rst=1 for 2 cycles with all inputs 1 -> all outputs 0; timeout_o=0 after release.
//  2 jump_req_i=1, addr=16'h0123, FLUSH_CYC=2 -> cycle0: jump_flag_o=1, jump_addr_o=0123,
//    flushes=1; cycle1: flushes=1, jump_flag_o=0; cycle2: all 0.
//  3 mc_start_i, then mc_done_i 5 cycles later -> stall_o=1 for 6 cycles (incl. the done cycle);
//    IRQ raised in cycle 2 is acked only once back in IDLE.
//  4 jump_req_i+irq_req_i+bus_busy_i same cycle, vec=16'h0010 -> jump serviced, irq_ack_o=0;
//    irq acked with jump_addr_o=0010 right after FLUSH completes.
//  5 mc_start_i, no mc_done_i, TOW=4 -> stall held 15 cycles, timeout_o=1 (sticky), IDLE next;
//    and done on the terminal cycle -> timeout_o=0.
//  6 rst asserted in cycle 1 of MC_WAIT -> outputs 0 immediately; IDLE after release;
//    a late mc_done_i has no effect.

Source files
------------

// File: rtl/pipe_hold_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hold_ctrl
// Description : Pipeline sequencer for the J1 set/hold pipeline registers.
//               Arbitrates jump, interrupt, multi-cycle-op and bus-stall
//               requests and drives the IF/ID and ID/EX hold (bubble)
//               inputs, the PC stall and the PC redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hold_ctrl #(
  parameter int AW        = 16,
  parameter int FLUSH_CYC = 2,
  parameter int TOW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump_req_i,
  input  logic [AW-1:0] jump_addr_i,
  input  logic          mc_start_i,
  input  logic          mc_done_i,
  input  logic          bus_busy_i,
  input  logic          irq_req_i,
  input  logic [AW-1:0] irq_vec_i,
  output logic          stall_o,
  output logic          flush_ifid_o,
  output logic          flush_idex_o,
  output logic          jump_flag_o,
  output logic [AW-1:0] jump_addr_o,
  output logic          irq_ack_o,
  output logic          timeout_o
);

  // Flush counter only has to hold FLUSH_CYC-2 (cycles left after the
  // request cycle and the current FLUSH cycle).
  localparam int FCW = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FCW-1:0] FL_LOAD = FCW'((FLUSH_CYC > 1) ? FLUSH_CYC - 2 : 0);
  // Last MC_WAIT cycle: the count reaches 2**TOW-1 with this cycle.
  localparam logic [TOW-1:0] TC_LAST = {{(TOW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FLUSH   = 2'd1,
    S_MC_WAIT = 2'd2
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [FCW-1:0] r_fcnt, w_fcnt_nxt;
  logic [TOW-1:0] r_tcnt, w_tcnt_nxt;
  logic           r_timeout, w_timeout_nxt;
  logic [AW-1:0]  r_addr, w_addr_nxt;

  logic           w_stall, w_fl_ifid, w_fl_idex, w_jflag, w_ack;
  logic [AW-1:0]  w_addr_out;

  // State, counters, sticky timeout and held redirect address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_fcnt    <= '0;
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
      r_addr    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_fcnt    <= w_fcnt_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_timeout <= w_timeout_nxt;
      r_addr    <= w_addr_nxt;
    end
  end

  // Request arbitration, next-state and same-cycle pipeline controls.
  always_comb begin
    w_state_nxt   = r_state;
    w_fcnt_nxt    = r_fcnt;
    w_tcnt_nxt    = r_tcnt;
    w_timeout_nxt = r_timeout;
    w_addr_nxt    = r_addr;
    w_stall       = 1'b0;
    w_fl_ifid     = 1'b0;
    w_fl_idex     = 1'b0;
    w_jflag       = 1'b0;
    w_ack         = 1'b0;
    w_addr_out    = r_addr;
    case (r_state)
      S_IDLE: begin
        if (jump_req_i) begin
          w_jflag    = 1'b1;
          w_fl_ifid  = 1'b1;
          w_fl_idex  = 1'b1;
          w_addr_out = jump_addr_i;
          w_addr_nxt = jump_addr_i;
          if (FLUSH_CYC > 1) begin
            w_state_nxt = S_FLUSH;
            w_fcnt_nxt  = FL_LOAD;
          end
        end else if (mc_start_i) begin
          w_stall     = 1'b1;
          w_fl_idex   = 1'b1;
          w_tcnt_nxt  = '0;
          w_state_nxt = S_MC_WAIT;
        end else if (irq_req_i) begin
          w_jflag    = 1'b1;
          w_ack      = 1'b1;
          w_fl_ifid  = 1'b1;
          w_fl_idex  = 1'b1;
          w_addr_out = irq_vec_i;
          w_addr_nxt = irq_vec_i;
          if (FLUSH_CYC > 1) begin
            w_state_nxt = S_FLUSH;
            w_fcnt_nxt  = FL_LOAD;
          end
        end else if (bus_busy_i) begin
          w_stall   = 1'b1;
          w_fl_idex = 1'b1;
        end
      end
      S_FLUSH: begin
        // Pending irq and new EX requests wait; EX only holds a bubble here.
        w_fl_ifid = 1'b1;
        w_fl_idex = 1'b1;
        if (r_fcnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_fcnt_nxt = r_fcnt - 1'b1;
        end
      end
      S_MC_WAIT: begin
        w_stall   = 1'b1;
        w_fl_idex = 1'b1;
        if (r_tcnt != TC_LAST) begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
        // Done on the terminal cycle is a normal completion, not a timeout.
        if (mc_done_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_tcnt == TC_LAST) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Every output, combinational ones included, is forced low during reset.
  assign stall_o      = w_stall   & ~rst;
  assign flush_ifid_o = w_fl_ifid & ~rst;
  assign flush_idex_o = w_fl_idex & ~rst;
  assign jump_flag_o  = w_jflag   & ~rst;
  assign irq_ack_o    = w_ack     & ~rst;
  assign timeout_o    = r_timeout & ~rst;
  assign jump_addr_o  = rst ? '0 : w_addr_out;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hold_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hold_ctrl
// Description : Self-checking bench for pipe_hold_ctrl (AW=16, FLUSH_CYC=2,
//               TOW=4). Table of single-cycle vectors plus hand sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hold_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_req_i, mc_start_i, mc_done_i, bus_busy_i, irq_req_i;
  logic [15:0] jump_addr_i, irq_vec_i;
  logic        stall_o, flush_ifid_o, flush_idex_o, jump_flag_o, irq_ack_o, timeout_o;
  logic [15:0] jump_addr_o;

  int n_checks = 0;
  int n_errors = 0;

  pipe_hold_ctrl #(.AW(16), .FLUSH_CYC(2), .TOW(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_req_i   (jump_req_i),
    .jump_addr_i  (jump_addr_i),
    .mc_start_i   (mc_start_i),
    .mc_done_i    (mc_done_i),
    .bus_busy_i   (bus_busy_i),
    .irq_req_i    (irq_req_i),
    .irq_vec_i    (irq_vec_i),
    .stall_o      (stall_o),
    .flush_ifid_o (flush_ifid_o),
    .flush_idex_o (flush_idex_o),
    .jump_flag_o  (jump_flag_o),
    .jump_addr_o  (jump_addr_o),
    .irq_ack_o    (irq_ack_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        r, jr;
    logic [15:0] ja;
    logic        ms, md, bb, ir;
    logic [15:0] iv;
    logic [21:0] exp;
  } vec_t;

  // Expected pack: {stall, flush_ifid, flush_idex, jump_flag, addr, ack, timeout}
  function automatic logic [21:0] E(input logic s, input logic fi, input logic fe,
                                    input logic jf, input logic [15:0] a,
                                    input logic ak, input logic to);
    return {s, fi, fe, jf, a, ak, to};
  endfunction

  function automatic vec_t mk(input string n, input logic r, input logic jr,
                              input logic [15:0] ja, input logic ms, input logic md,
                              input logic bb, input logic ir, input logic [15:0] iv,
                              input logic [21:0] e);
    vec_t v;
    v.name = n; v.r = r; v.jr = jr; v.ja = ja; v.ms = ms; v.md = md;
    v.bb = bb; v.ir = ir; v.iv = iv; v.exp = e;
    return v;
  endfunction

  // One clock cycle: drive after the rising edge, compare at the falling edge.
  task automatic step(input vec_t v);
    logic [21:0] got;
    @(posedge clk);
    #1;
    rst = v.r; jump_req_i = v.jr; jump_addr_i = v.ja; mc_start_i = v.ms;
    mc_done_i = v.md; bus_busy_i = v.bb; irq_req_i = v.ir; irq_vec_i = v.iv;
    @(negedge clk);
    got = {stall_o, flush_ifid_o, flush_idex_o, jump_flag_o, jump_addr_o, irq_ack_o, timeout_o};
    n_checks++;
    if (got !== v.exp) begin
      n_errors++;
      $display("FAIL %s: got s/fi/fe/jf=%b addr=%h ack/to=%b, want s/fi/fe/jf=%b addr=%h ack/to=%b",
               v.name, got[21:18], got[17:2], got[1:0], v.exp[21:18], v.exp[17:2], v.exp[1:0]);
    end
  endtask

  vec_t tbl[20];

  initial begin
    rst = 1'b1; jump_req_i = 1'b0; jump_addr_i = '0; mc_start_i = 1'b0;
    mc_done_i = 1'b0; bus_busy_i = 1'b0; irq_req_i = 1'b0; irq_vec_i = '0;

    //            name          r  jr  ja        ms md bb ir iv        expected
    tbl[0]  = mk("rst_all1_a", 1, 1, 16'hFFFF, 1, 1, 1, 1, 16'hFFFF, E(0,0,0,0,16'h0000,0,0));
    tbl[1]  = mk("rst_all1_b", 1, 1, 16'hFFFF, 1, 1, 1, 1, 16'hFFFF, E(0,0,0,0,16'h0000,0,0));
    tbl[2]  = mk("post_rst",   0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, E(0,0,0,0,16'h0000,0,0));
    tbl[3]  = mk("jump_c0",    0, 1, 16'h0123, 0, 0, 0, 0, 16'h0000, E(0,1,1,1,16'h0123,0,0));
    tbl[4]  = mk("jump_c1",    0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, E(0,1,1,0,16'h0123,0,0));
    tbl[5]  = mk("jump_c2",    0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, E(0,0,0,0,16'h0123,0,0));
    tbl[6]  = mk("bus_busy",   0, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, E(1,0,1,0,16'h0123,0,0));
    tbl[7]  = mk("jirqbb_c0",  0, 1, 16'h0200, 0, 0, 1, 1, 16'h0010, E(0,1,1,1,16'h0200,0,0));
    tbl[8]  = mk("jirqbb_c1",  0, 0, 16'h0000, 0, 0, 1, 1, 16'h0010, E(0,1,1,0,16'h0200,0,0));
    tbl[9]  = mk("irq_ack",    0, 0, 16'h0000, 0, 0, 1, 1, 16'h0010, E(0,1,1,1,16'h0010,1,0));
    tbl[10] = mk("irq_flush",  0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, E(0,1,1,0,16'h0010,0,0));
    tbl[11] = mk("irq_idle",   0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, E(0,0,0,0,16'h0010,0,0));
    tbl[12] = mk("jmp_vs_mc",  0, 1, 16'h0345, 1, 0, 0, 0, 16'h0000, E(0,1,1,1,16'h0345,0,0));
    tbl[13] = mk("fl_ign_mc",  0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, E(0,1,1,0,16'h0345,0,0));
    tbl[14] = mk("mc_dropped", 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, E(0,0,0,0,16'h0345,0,0));
    tbl[15] = mk("mc_vs_irq",  0, 0, 16'h0000, 1, 0, 0, 1, 16'h0044, E(1,0,1,0,16'h0345,0,0));
    tbl[16] = mk("mc_done1",   0, 0, 16'h0000, 0, 1, 0, 1, 16'h0044, E(1,0,1,0,16'h0345,0,0));
    tbl[17] = mk("irq_after",  0, 0, 16'h0000, 0, 0, 0, 1, 16'h0044, E(0,1,1,1,16'h0044,1,0));
    tbl[18] = mk("irq_fl2",    0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, E(0,1,1,0,16'h0044,0,0));
    tbl[19] = mk("idle2",      0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, E(0,0,0,0,16'h0044,0,0));

    for (int i = 0; i < 20; i++) step(tbl[i]);

    // mc op done 5 cycles after start; irq raised in cycle 2 waits for IDLE.
    // Bus busy and a stray jump during MC_WAIT are ignored.
    step(mk("mc3_c0", 0, 0, 16'h0, 1, 0, 0, 0, 16'h0077, E(1,0,1,0,16'h0044,0,0)));
    step(mk("mc3_c1", 0, 0, 16'h0, 0, 0, 0, 0, 16'h0077, E(1,0,1,0,16'h0044,0,0)));
    step(mk("mc3_c2", 0, 0, 16'h0, 0, 0, 0, 1, 16'h0077, E(1,0,1,0,16'h0044,0,0)));
    step(mk("mc3_c3", 0, 0, 16'h0, 0, 0, 1, 1, 16'h0077, E(1,0,1,0,16'h0044,0,0)));
    step(mk("mc3_c4", 0, 1, 16'h0999, 0, 0, 0, 1, 16'h0077, E(1,0,1,0,16'h0044,0,0)));
    step(mk("mc3_done", 0, 0, 16'h0, 0, 1, 0, 1, 16'h0077, E(1,0,1,0,16'h0044,0,0)));
    step(mk("mc3_irq", 0, 0, 16'h0, 0, 0, 0, 1, 16'h0077, E(0,1,1,1,16'h0077,1,0)));
    step(mk("mc3_fl", 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, E(0,1,1,0,16'h0077,0,0)));
    step(mk("mc3_idle", 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, E(0,0,0,0,16'h0077,0,0)));

    // Timeout: start cycle plus 15 MC_WAIT cycles of stall, then sticky flag.
    step(mk("to_start", 0, 0, 16'h0, 1, 0, 0, 0, 16'h0, E(1,0,1,0,16'h0077,0,0)));
    for (int k = 1; k <= 15; k++)
      step(mk($sformatf("to_wait%0d", k), 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, E(1,0,1,0,16'h0077,0,0)));
    step(mk("to_idle", 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, E(0,0,0,0,16'h0077,0,1)));
    step(mk("to_sticky", 0, 0, 16'h0, 0, 0, 1, 0, 16'h0, E(1,0,1,0,16'h0077,0,1)));
    step(mk("to_clr_rst", 1, 0, 16'h0, 0, 0, 0, 0, 16'h0, E(0,0,0,0,16'h0000,0,0)));
    step(mk("to_clr_rel", 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, E(0,0,0,0,16'h0000,0,0)));

    // Done on the terminal cycle wins over timeout.
    step(mk("tt_start", 0, 0, 16'h0, 1, 0, 0, 0, 16'h0, E(1,0,1,0,16'h0000,0,0)));
    for (int k = 1; k <= 14; k++)
      step(mk($sformatf("tt_wait%0d", k), 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, E(1,0,1,0,16'h0000,0,0)));
    step(mk("tt_done", 0, 0, 16'h0, 0, 1, 0, 0, 16'h0, E(1,0,1,0,16'h0000,0,0)));
    step(mk("tt_idle", 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, E(0,0,0,0,16'h0000,0,0)));

    // Reset in cycle 1 of MC_WAIT abandons the op; late done is ignored.
    step(mk("rs_start", 0, 0, 16'h0, 1, 0, 0, 0, 16'h0, E(1,0,1,0,16'h0000,0,0)));
    step(mk("rs_rst", 1, 0, 16'h0, 0, 0, 1, 0, 16'h0, E(0,0,0,0,16'h0000,0,0)));
    step(mk("rs_late_done", 0, 0, 16'h0, 0, 1, 0, 0, 16'h0, E(0,0,0,0,16'h0000,0,0)));
    step(mk("rs_idle", 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, E(0,0,0,0,16'h0000,0,0)));
    step(mk("rs_jump", 0, 1, 16'h0abc, 0, 0, 0, 0, 16'h0, E(0,1,1,1,16'h0abc,0,0)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
